// File: rtl/laser_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : laser_pkg
// Description : Types and defaults shared by the laser link receiver,
//               transmitter and board-level ChipInterface.
//               rx_state_t            - receiver FSM state encoding
//               DEFAULT_CLKS_PER_BIT  - clock cycles per serial bit
//               DEFAULT_DATA_BITS     - payload bits per frame
// Revision    : 1.0 - initial release
// ============================================================================
package laser_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 8;
  localparam int DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer for one asynchronous input bit.
// Ports       : clock (in)  - destination clock
//               reset (in)  - asynchronous active-high reset
//               d     (in)  - asynchronous input
//               q     (out) - synchronized output
// Parameter   : RESET_VAL   - value both flops take during reset
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/laser_rx_deser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : laser_rx_deser
// Description : UART-style deserializer for the optical link. Start bit is
//               qualified at mid-bit, data bits are sampled LSB-first one bit
//               period apart, then the stop bit decides between a data_valid
//               or a framing_err pulse.
// Ports       : clock       (in)  - system clock
//               reset       (in)  - asynchronous active-high reset
//               en          (in)  - receiver enable; low forces idle
//               rx_in       (in)  - asynchronous serial line, idle high
//               data_out    (out) - last correctly framed payload
//               data_valid  (out) - one-cycle pulse, data_out is new
//               framing_err (out) - one-cycle pulse, stop bit was low
//               busy        (out) - FSM is not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module laser_rx_deser
  import laser_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_err,
  output logic                 busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] data_out_n;
  logic                 valid_n, ferr_n;
  // flushed fills with ones once the synchronizer holds real line samples;
  // armed means the real line has been seen high since reset / enable.
  logic [1:0]           flushed;
  logic                 armed, armed_n;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      flushed     <= '0;
      armed       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      data_out    <= data_out_n;
      data_valid  <= valid_n;
      framing_err <= ferr_n;
      flushed     <= {flushed[0], 1'b1};
      armed       <= armed_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    data_out_n = data_out;
    valid_n    = 1'b0;
    ferr_n     = 1'b0;
    // A low level right after reset or re-enable is the middle of someone
    // else's frame, not a start edge: only start once the line was high.
    armed_n    = en & (armed | (flushed[1] & rx_s));

    if (!en) begin
      state_n   = IDLE;
      cnt_n     = '0;
      bit_idx_n = '0;
      shreg_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt_n     = '0;
            bit_idx_n = '0;
            state_n   = rx_s ? IDLE : DATA;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            shreg_n                = shreg >> 1;
            shreg_n[DATA_BITS-1]   = rx_s;
            cnt_n                  = '0;
            if (bit_idx == IDX_LAST) begin
              bit_idx_n = '0;
              state_n   = STOP;
            end else begin
              bit_idx_n = bit_idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt_n = '0;
            if (rx_s) begin
              data_out_n = shreg;
              valid_n    = 1'b1;
              state_n    = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = WAIT_HIGH;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/laser_rx_deser.md
LASER_RX_DESER -- requirements
Module: laser_rx_deser

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter CLKS_PER_BIT, default 8: clock cycles per serial bit; even, >= 4.
REQ-003 Parameter DATA_BITS, default 8: payload bits per frame.
REQ-004 clock  input  1  system clock (50 MHz on board).
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 en  input  1  receiver enable; low forces idle.
REQ-007 rx_in  input  1  asynchronous photodiode/loopback serial line; idle high.
REQ-008 data_out  output  DATA_BITS  last correctly framed payload.
REQ-009 data_valid  output  1  one-cycle pulse; data_out is new this cycle.
REQ-010 framing_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 rx_in SHALL pass through a 2-flop synchronizer; all logic below uses the synchronized line rx_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-014 IDLE: if en=1 and rx_s=0, go to START with cnt=0; otherwise stay.
REQ-015 START: cnt increments each cycle; at cnt=CLKS_PER_BIT/2-1, rx_s=0 goes to DATA (cnt=0, bit_idx=0); rx_s=1 is a glitch and goes to IDLE with no pulse.
REQ-016 DATA: at cnt=CLKS_PER_BIT-1, sample rx_s into shift register LSB-first, set cnt=0 and increment bit_idx; after sample DATA_BITS-1, go to STOP.
REQ-017 STOP: at cnt=CLKS_PER_BIT-1, sample rx_s.
REQ-018 STOP sample=1: data_out loads the shift register, data_valid=1 for exactly the next cycle, and the FSM goes to IDLE.
REQ-019 STOP sample=0: framing_err=1 for exactly the next cycle, data_out is unchanged, and the FSM goes to WAIT_HIGH.
REQ-020 WAIT_HIGH: stay until rx_s=1, then go to IDLE; a line held low SHALL NOT produce repeated frames or errors.
REQ-021 data_valid and framing_err SHALL never be asserted in the same cycle.
REQ-022 en deasserted in any state SHALL force IDLE on the next edge: no pulses, data_out held, partial shift register discarded.
REQ-023 Back-to-back frames: a start bit that begins the cycle after the stop sample SHALL be received with no lost frame.
REQ-024 cnt SHALL be wide enough for CLKS_PER_BIT-1, with no wrap; bit_idx SHALL be wide enough for DATA_BITS-1.
REQ-025 data_out, data_valid and framing_err SHALL be registered outputs.

Reset
REQ-026 Reset SHALL force state=IDLE, cnt=0, bit_idx=0, shift register=0, data_out=0, data_valid=0, framing_err=0, busy=0, and synchronizer flops=1 (idle line).
REQ-027 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, reception starts only on a new falling edge.

Structure
REQ-028 Package laser_pkg SHALL hold the rx_state_t enum and the constants DEFAULT_CLKS_PER_BIT=8 and DEFAULT_DATA_BITS=8, shared with the transmitter and ChipInterface.
REQ-029 The synchronizer SHALL be a separate sub-module, sync2 (1 bit, reset value parameterized), instantiated once.
REQ-030 The FSM, counters and shift register SHALL stay in laser_rx_deser.

Verification (CLKS_PER_BIT=8, DATA_BITS=8, 10 ns clock)
REQ-031 Frame with start 0, 0xA5 LSB-first and stop 1 -> exactly one data_valid pulse, data_out=8'hA5, framing_err never high, busy low after the pulse.
REQ-032 Frames 0x3C and 0xFF back-to-back with no idle gap -> two data_valid pulses, data_out 8'h3C then 8'hFF.
REQ-033 rx_in low for 3 cycles, then high -> START aborts, no pulses, busy returns to 0 within 8 cycles.
REQ-034 Frame 0x55 with stop bit 0, line then held low for 40 cycles, then high -> one framing_err pulse, data_out keeps its previous value, no further pulses; next valid frame 0x12 gives data_out=8'h12.
REQ-035 Reset asserted at bit 4 of frame 0x81 -> all outputs 0 immediately (asynchronously); remainder of that frame produces no pulse; next frame 0x7E gives data_out=8'h7E.
REQ-036 en dropped mid-frame for 1 cycle -> no pulse; frame 0x99 sent after en is restored is received correctly.
